// File: rtl/alu_pkg.sv
// alu_pkg -- shared ALU opcode encodings and RV32I decode constants.
// Imported by the issue stage (alu_issue) and by the ALU that consumes its
// alu_control output, so both sides agree on a single encoding.
package alu_pkg;

  // ALU operation selector driven on alu_control.
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1010,
    ALU_SRA = 4'b1011
  } alu_op_e;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 values of the supported register/immediate ALU ops.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 values: base encoding and the alternate (SUB/SRA) encoding.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/imm_gen.sv
// imm_gen -- RV32I immediate extraction.
// Ports:
//   instr  : in,  instruction bits [31:7] (the opcode field is not needed)
//   imm_i  : out, sign-extended I-type immediate
//   imm_s  : out, sign-extended S-type immediate
//   imm_u  : out, U-type immediate (upper 20 bits, low 12 bits zero)
module imm_gen #(
  parameter int REG_WIDTH = 32
) (
  input  logic [31:7]          instr,
  output logic [REG_WIDTH-1:0] imm_i,
  output logic [REG_WIDTH-1:0] imm_s,
  output logic [REG_WIDTH-1:0] imm_u
);

  // Size casts of signed values sign-extend to REG_WIDTH.
  assign imm_i = REG_WIDTH'($signed(instr[31:20]));
  assign imm_s = REG_WIDTH'($signed({instr[31:25], instr[11:7]}));
  assign imm_u = REG_WIDTH'($signed({instr[31:12], 12'h000}));

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- decodes an RV32I instruction into ALU opcode/operands and
// issues it through a 2-entry skid buffer (main + skid registers).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronously discards every buffered op
//   in_valid/in_ready   : upstream handshake; instr, pc, rs1_data, rs2_data
//                         are sampled on an input transfer
//   out_valid/out_ready : downstream handshake
//   alu_control         : ALU opcode (alu_pkg::alu_op_e encoding)
//   op1, op2            : ALU operands
//   rd                  : destination register (0 for branches/stores)
//   illegal             : unsupported instruction, issued as ADD 0,0
module alu_issue
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [REG_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0] rs1_data,
  input  logic [REG_WIDTH-1:0] rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           alu_control,
  output logic [REG_WIDTH-1:0] op1,
  output logic [REG_WIDTH-1:0] op2,
  output logic [4:0]           rd,
  output logic                 illegal
);

  typedef struct packed {
    alu_op_e                alu_control;
    logic [REG_WIDTH-1:0]   op1;
    logic [REG_WIDTH-1:0]   op2;
    logic [4:0]             rd;
    logic                   illegal;
  } issue_t;

  localparam issue_t RESET_ISSUE = '{
    alu_control: ALU_ADD, op1: '0, op2: '0, rd: '0, illegal: 1'b0
  };

  // ---------------------------------------------------------------- decode
  logic [REG_WIDTH-1:0] imm_i, imm_s, imm_u;

  imm_gen #(.REG_WIDTH(REG_WIDTH)) u_imm_gen (
    .instr (instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_u (imm_u)
  );

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [REG_WIDTH-1:0] shamt_reg, shamt_imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Shift amounts are confined to [4:0] so the ALU never shifts by >= 32.
  assign shamt_reg = REG_WIDTH'(rs2_data[4:0]);
  assign shamt_imm = REG_WIDTH'(instr[24:20]);

  issue_t dec;
  logic   bad;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    dec             = RESET_ISSUE;
    dec.rd          = instr[11:7];
    bad             = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_BASE)     dec.alu_control = ALU_ADD;
            else if (funct7 == F7_ALT) dec.alu_control = ALU_SUB;
            else                       bad = 1'b1;
          end
          F3_SLL: begin
            dec.alu_control = ALU_SLL;
            dec.op2         = shamt_reg;
            bad             = (funct7 != F7_BASE);
          end
          F3_SRL_SRA: begin
            dec.alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.op2         = shamt_reg;
            bad             = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          F3_XOR: begin dec.alu_control = ALU_XOR; bad = (funct7 != F7_BASE); end
          F3_OR:  begin dec.alu_control = ALU_OR;  bad = (funct7 != F7_BASE); end
          F3_AND: begin dec.alu_control = ALU_AND; bad = (funct7 != F7_BASE); end
          default: bad = 1'b1;  // SLT/SLTU
        endcase
      end
      OPC_OP_IMM: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i;
        // Only the shift-immediates constrain instr[31:25]; there is no SUBI.
        case (funct3)
          F3_ADD_SUB: dec.alu_control = ALU_ADD;
          F3_SLL: begin
            dec.alu_control = ALU_SLL;
            dec.op2         = shamt_imm;
            bad             = (funct7 != F7_BASE);
          end
          F3_SRL_SRA: begin
            dec.alu_control = instr[30] ? ALU_SRA : ALU_SRL;
            dec.op2         = shamt_imm;
            bad             = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          F3_XOR:  dec.alu_control = ALU_XOR;
          F3_OR:   dec.alu_control = ALU_OR;
          F3_AND:  dec.alu_control = ALU_AND;
          default: bad = 1'b1;  // SLTI/SLTIU
        endcase
      end
      OPC_LOAD: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i;
      end
      OPC_STORE: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_s;
        dec.rd  = '0;
      end
      OPC_BRANCH: begin
        dec.alu_control = ALU_SUB;
        dec.op1         = rs1_data;
        dec.op2         = rs2_data;
        dec.rd          = '0;
      end
      OPC_LUI:   dec.op2 = imm_u;
      OPC_AUIPC: begin
        dec.op1 = pc;
        dec.op2 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        // Link address pc+4.
        dec.op1 = pc;
        dec.op2 = REG_WIDTH'(3'd4);
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec         = RESET_ISSUE;
      dec.rd      = instr[11:7];
      dec.illegal = 1'b1;
    end
  end

  // ----------------------------------------------------------- skid buffer
  logic   main_valid, skid_valid;
  issue_t main_q, skid_q;
  logic   in_fire, out_fire, skid_load;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  // Main is occupied and not draining: a new op has to park in skid.
  assign skid_load = !flush && main_valid && !out_ready && in_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= RESET_ISSUE;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      // Main is free this edge: refill from skid first to keep order.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (skid_load) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload has no reset; it is only observed behind skid_valid,
  // which is reset.
  always_ff @(posedge clk) begin
    if (skid_load) skid_q <= dec;
  end

  assign alu_control = main_q.alu_control;
  assign op1         = main_q.op1;
  assign op2         = main_q.op2;
  assign rd          = main_q.rd;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- self-checking bench for alu_issue: directed decode table,
// handshake corner sequences, then randomized traffic against a queue model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, op1, op2;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue #(.REG_WIDTH(32)) dut (
    .clk (clk), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .instr (instr),
    .pc (pc), .rs1_data (rs1_data), .rs2_data (rs2_data),
    .out_valid (out_valid), .out_ready (out_ready),
    .alu_control (alu_control), .op1 (op1), .op2 (op2),
    .rd (rd), .illegal (illegal)
  );

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctrl;
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111,
                         AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;

  // ------------------------------------------------------------ encoders
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rdn, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rdn, opc};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rdn, logic [6:0] opc);
    return {imm, rs1, f3, rdn, opc};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rdn, logic [6:0] opc);
    return {imm, rdn, opc};
  endfunction

  // ------------------------------------------------------ reference model
  // Names the operation from its mnemonic, then maps mnemonic to behaviour.
  function automatic string alu_name(bit is_imm, logic [6:0] f7, logic [2:0] f3);
    bit base = (f7 == 7'h00);
    bit alt  = (f7 == 7'h20);
    case (f3)
      3'd0: return (is_imm || base) ? "add" : (alt ? "sub" : "bad");
      3'd1: return base ? "sll" : "bad";
      3'd4: return (is_imm || base) ? "xor" : "bad";
      3'd5: return base ? "srl" : (alt ? "sra" : "bad");
      3'd6: return (is_imm || base) ? "or" : "bad";
      3'd7: return (is_imm || base) ? "and" : "bad";
      default: return "bad";
    endcase
  endfunction

  function automatic logic [3:0] code_of(string m);
    case (m)
      "and": return 4'b0000;
      "or":  return 4'b0001;
      "xor": return 4'b0011;
      "sub": return 4'b0110;
      "sll": return 4'b1000;
      "srl": return 4'b1010;
      "sra": return 4'b1011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic vec_t ref_decode(logic [31:0] ins, logic [31:0] p,
                                      logic [31:0] a, logic [31:0] b);
    vec_t r;
    string m;
    logic signed [11:0] i12, s12;
    int imm_i, imm_s;
    logic [31:0] imm_u;
    bit shift;
    i12   = ins[31:20];
    s12   = {ins[31:25], ins[11:7]};
    imm_i = i12;
    imm_s = s12;
    imm_u = {ins[31:12], 12'h000};
    r = '{instr: ins, pc: p, rs1: a, rs2: b, ctrl: 4'b0010, op1: 0, op2: 0,
          rd: ins[11:7], ill: 1'b0};
    case (ins[6:0])
      R, I: begin
        m = alu_name(ins[6:0] == I, ins[31:25], ins[14:12]);
        shift = (m == "sll" || m == "srl" || m == "sra");
        if (m == "bad") r.ill = 1'b1;
        else begin
          r.ctrl = code_of(m);
          r.op1  = a;
          if (ins[6:0] == R) r.op2 = shift ? b % 32 : b;
          else               r.op2 = shift ? 32'(ins[24:20]) : 32'(imm_i);
        end
      end
      LD:  begin r.op1 = a; r.op2 = 32'(imm_i); end
      ST:  begin r.op1 = a; r.op2 = 32'(imm_s); r.rd = 0; end
      BR:  begin r.ctrl = 4'b0110; r.op1 = a; r.op2 = b; r.rd = 0; end
      LUI: r.op2 = imm_u;
      AUI: begin r.op1 = p; r.op2 = imm_u; end
      JAL, JALR: begin r.op1 = p; r.op2 = 4; end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------- checks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_out(input string tag, input vec_t e);
    check({tag, ".alu_control"}, 32'(alu_control), 32'(e.ctrl));
    check({tag, ".op1"},         op1,              e.op1);
    check({tag, ".op2"},         op2,              e.op2);
    check({tag, ".rd"},          32'(rd),          32'(e.rd));
    check({tag, ".illegal"},     32'(illegal),     32'(e.ill));
  endtask

  task automatic drive(input vec_t v);
    instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fill both buffer entries with out_ready held low.
  task automatic fill_two(input vec_t a, input vec_t b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(a); tick;
    drive(b); tick;
    in_valid  = 1'b0;
    check("fill.in_ready",  32'(in_ready),  32'(0));
    check("fill.out_valid", 32'(out_valid), 32'(1));
  endtask

  task automatic single_issue(input string tag, input vec_t v);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(v);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(1));
    tick;
    in_valid = 1'b0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(1));
    check_out(tag, v);
    tick;
    check({tag, ".drained"}, 32'(out_valid), 32'(0));
  endtask

  vec_t vecs[$];
  vec_t q[$];

  initial begin
    // Directed vectors; expected fields computed by hand.
    vecs.push_back('{enc_r(7'h00,2,1,3'd0,3,R),  0, 5, 7,                   4'b0010, 5, 7, 3, 0});
    vecs.push_back('{enc_r(7'h20,2,1,3'd0,6,R),  0, 10, 3,                  4'b0110, 10, 3, 6, 0});
    vecs.push_back('{enc_i(12'h403,1,3'd5,4,I),  0, 32'h80000000, 0,        4'b1011, 32'h80000000, 3, 4, 0});
    vecs.push_back('{enc_r(7'h00,2,1,3'd1,7,R),  0, 1, 32'h21,              4'b1000, 1, 1, 7, 0});
    vecs.push_back('{enc_r(7'h20,2,1,3'd5,8,R),  0, 32'hF0, 32'hFFFFFFE5,   4'b1011, 32'hF0, 5, 8, 0});
    vecs.push_back('{enc_u(20'h12345,5,AUI),     32'h100, 0, 0,             4'b0010, 32'h100, 32'h12345000, 5, 0});
    vecs.push_back('{enc_u(20'hFFFFF,9,LUI),     32'h500, 9, 9,             4'b0010, 0, 32'hFFFFF000, 9, 0});
    vecs.push_back('{enc_i(12'hFFC,1,3'd2,10,LD),0, 32'h1000, 0,            4'b0010, 32'h1000, 32'hFFFFFFFC, 10, 0});
    vecs.push_back('{enc_s(12'hFF8,2,1,3'd2,ST), 0, 32'h2000, 3,            4'b0010, 32'h2000, 32'hFFFFFFF8, 0, 0});
    vecs.push_back('{enc_r(7'h00,2,1,3'd0,9,BR), 0, 20, 30,                 4'b0110, 20, 30, 0, 0});
    vecs.push_back('{enc_u(20'h00010,1,JAL),     32'h200, 1, 2,             4'b0010, 32'h200, 4, 1, 0});
    vecs.push_back('{enc_i(12'h000,5,3'd0,1,JALR),32'h300, 1, 2,            4'b0010, 32'h300, 4, 1, 0});
    vecs.push_back('{enc_i(12'h800,3,3'd7,2,I),  0, 32'hFFFFFFFF, 0,        4'b0000, 32'hFFFFFFFF, 32'hFFFFF800, 2, 0});
    vecs.push_back('{enc_r(7'h00,3,2,3'd2,1,R),  0, 11, 12,                 4'b0010, 0, 0, 1, 1});
    vecs.push_back('{enc_r(7'h01,2,1,3'd0,11,R), 0, 11, 12,                 4'b0010, 0, 0, 11, 1});
    vecs.push_back('{enc_r(7'h00,2,1,3'd0,12,7'h7F), 0, 11, 12,             4'b0010, 0, 0, 12, 1});
    vecs.push_back('{enc_i(12'h01F,1,3'd1,13,I), 0, 6, 0,                   4'b1000, 6, 31, 13, 0});
    vecs.push_back('{enc_i(12'h401,1,3'd1,14,I), 0, 6, 0,                   4'b0010, 0, 0, 14, 1});
    vecs.push_back('{enc_i(12'h0F0,1,3'd4,15,I), 0, 32'hFF, 0,              4'b0011, 32'hFF, 32'hF0, 15, 0});
    vecs.push_back('{enc_r(7'h00,2,1,3'd6,16,R), 0, 32'hA, 32'h5,           4'b0001, 32'hA, 32'h5, 16, 0});
    vecs.push_back('{enc_r(7'h00,2,1,3'd5,17,R), 0, 32'h80, 32'h40,         4'b1010, 32'h80, 0, 17, 0});

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;

    // Reset values, sampled before the first clock edge.
    #3;
    check("rst.out_valid",   32'(out_valid),   32'(0));
    check("rst.in_ready",    32'(in_ready),    32'(1));
    check("rst.alu_control", 32'(alu_control), 32'(4'b0010));
    check("rst.op1",         op1,              0);
    check("rst.op2",         op2,              0);
    check("rst.rd",          32'(rd),          32'(0));
    check("rst.illegal",     32'(illegal),     32'(0));
    @(negedge clk);
    reset = 1'b0;
    tick;

    // Directed decode table, one op at a time.
    foreach (vecs[i]) single_issue($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: 3 ops offered while out_ready=0, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[0]);
    check("bp.in_ready0", 32'(in_ready), 32'(1));
    tick;
    check("bp.out_valid", 32'(out_valid), 32'(1));
    check("bp.in_ready1", 32'(in_ready),  32'(1));
    check_out("bp.hold1", vecs[0]);
    drive(vecs[1]);
    tick;
    check("bp.in_ready_fell", 32'(in_ready), 32'(0));
    check_out("bp.hold2", vecs[0]);
    drive(vecs[5]);
    tick;
    check("bp.in_ready_low", 32'(in_ready), 32'(0));
    check_out("bp.hold3", vecs[0]);
    out_ready = 1'b1;
    tick;
    check("bp.second_valid", 32'(out_valid), 32'(1));
    check("bp.in_ready_back", 32'(in_ready), 32'(1));
    check_out("bp.second", vecs[1]);
    tick;
    in_valid = 1'b0;
    check("bp.third_valid", 32'(out_valid), 32'(1));
    check_out("bp.third", vecs[5]);
    tick;
    check("bp.empty", 32'(out_valid), 32'(0));

    // Flush with both entries full; same-cycle input is ignored.
    fill_two(vecs[0], vecs[1]);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    drive(vecs[2]);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", 32'(out_valid), 32'(0));
    check("flush.in_ready",  32'(in_ready),  32'(1));
    tick;
    check("flush.no_stale1", 32'(out_valid), 32'(0));
    tick;
    check("flush.no_stale2", 32'(out_valid), 32'(0));
    single_issue("post_flush", vecs[3]);

    // Reset with both entries full.
    fill_two(vecs[0], vecs[1]);
    reset = 1'b1;
    #1;
    check("mid_rst.out_valid",   32'(out_valid),   32'(0));
    check("mid_rst.in_ready",    32'(in_ready),    32'(1));
    check("mid_rst.alu_control", 32'(alu_control), 32'(4'b0010));
    check("mid_rst.op1",         op1,              0);
    check("mid_rst.op2",         op2,              0);
    check("mid_rst.rd",          32'(rd),          32'(0));
    check("mid_rst.illegal",     32'(illegal),     32'(0));
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    tick;
    check("post_rst.no_stale", 32'(out_valid), 32'(0));
    single_issue("post_rst", vecs[6]);

    // Randomized traffic against a queue model of the 2-entry buffer.
    begin
      logic [6:0] opcs [10];
      logic [6:0] f7;
      bit         iv, ordy, fl;
      vec_t       nv;
      opcs = '{R, I, LD, ST, BR, LUI, AUI, JAL, JALR, 7'h00};
      for (int cyc = 0; cyc < 3000; cyc++) begin
        check("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("rnd.in_ready",  32'(in_ready),  32'(q.size() < 2));
        if (q.size() > 0) check_out("rnd", q[0]);

        iv   = ($urandom_range(0, 9) < 6);
        ordy = ($urandom_range(0, 9) < 6);
        fl   = ($urandom_range(0, 39) == 0);
        case ($urandom_range(0, 3))
          0:       f7 = 7'h00;
          1, 2:    f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        nv.instr = $urandom;
        nv.instr[31:25] = (nv.instr[0]) ? 7'h00 : f7;
        nv.instr[6:0] = opcs[$urandom_range(0, 9)];
        if (nv.instr[6:0] == 7'h00) nv.instr[6:0] = 7'($urandom);
        nv = ref_decode(nv.instr, $urandom, $urandom, $urandom);

        in_valid = iv; out_ready = ordy; flush = fl;
        drive(nv);

        if (fl) q.delete();
        else begin
          bit can_take;
          can_take = (q.size() < 2);
          if (q.size() > 0 && ordy) void'(q.pop_front());
          if (iv && can_take) q.push_back(nv);
        end
        tick;
      end
      in_valid = 1'b0; flush = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
